// File: rtl/capture_readout.sv
// Capture-bank reader: streams stored samples out in address order over valid/ready.
// Optional build macro CAPTURE_READOUT_CHECKSUM_EN adds o_checksum (sum of accepted words).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for i_start; range checked here
// S_ISSUE  | issuing one bank read per cycle while FIFO credit allows
// S_DRAIN  | all reads issued; waiting for in-flight reads and FIFO to empty
// S_FIN    | done pulse (plus err for a bad range), then back to idle
module capture_readout #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int NUM_BANKS  = 3,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [1:0]           i_bank_first,
  input  logic [1:0]           i_bank_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [ADDR_W-1:0]    o_mem_address,
  output logic [NUM_BANKS-1:0] o_mem_rden,
  input  logic [DATA_W-1:0]    i_mem_q0,
  input  logic [DATA_W-1:0]    i_mem_q1,
  input  logic [DATA_W-1:0]    i_mem_q2,
  output logic [DATA_W-1:0]    o_out_data,
  output logic [1:0]           o_out_bank,
  output logic                 o_out_last,
  output logic                 o_out_valid,
`ifdef CAPTURE_READOUT_CHECKSUM_EN
  output logic [15:0]          o_checksum,
`endif
  input  logic                 i_out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t              r_state;
  logic [1:0]          r_bank;
  logic [1:0]          r_bank_last;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_err_pend;

  logic [RD_LATENCY-1:0]      r_dl_valid;
  logic [RD_LATENCY-1:0][1:0] r_dl_bank;
  logic [RD_LATENCY-1:0]      r_dl_last;
  logic [CNT_W-1:0]           r_outstanding;

  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [1:0]          r_fifo_bank [FIFO_DEPTH];
  logic                r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_fifo_count;

  logic                w_pop;
  logic [CNT_W:0]      w_used;
  logic                w_issue;
  logic                w_issue_last;
  logic                w_range_ok;
  logic                w_drained;
  logic                w_fifo_wr;
  logic [DATA_W-1:0]   w_rd_q;
  logic [NUM_BANKS-1:0] w_onehot;

  assign o_out_valid = (r_fifo_count != '0);
  assign w_pop       = o_out_valid & i_out_ready;

  // Credit counts the word leaving this cycle, so RD_LATENCY+1 entries sustain full rate.
  assign w_used       = {1'b0, r_outstanding} + {1'b0, r_fifo_count} - {{CNT_W{1'b0}}, w_pop};
  assign w_issue      = (r_state == S_ISSUE) && (w_used < DEPTH_C);
  assign w_issue_last = w_issue && (r_addr == ADDR_MAX) && (r_bank == r_bank_last);
  assign w_range_ok   = (i_bank_first <= i_bank_last) && (int'(i_bank_last) < NUM_BANKS);
  assign w_drained    = (w_used == '0);
  assign w_fifo_wr    = r_dl_valid[RD_LATENCY-1];
  assign w_onehot     = NUM_BANKS'(1) << r_bank;

  assign o_mem_rden    = w_issue ? w_onehot : '0;
  assign o_mem_address = r_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

  assign o_out_data = o_out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign o_out_bank = o_out_valid ? r_fifo_bank[r_rd_ptr] : 2'd0;
  assign o_out_last = o_out_valid ? r_fifo_last[r_rd_ptr] : 1'b0;

  always_comb begin
    w_rd_q = i_mem_q2;
    case (r_dl_bank[RD_LATENCY-1])
      2'd0:    w_rd_q = i_mem_q0;
      2'd1:    w_rd_q = i_mem_q1;
      default: w_rd_q = i_mem_q2;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bank      <= 2'd0;
      r_bank_last <= 2'd0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_pend  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_range_ok) begin
              r_bank      <= i_bank_first;
              r_bank_last <= i_bank_last;
              r_addr      <= '0;
              r_err_pend  <= 1'b0;
              r_state     <= S_ISSUE;
            end else begin
              r_err_pend <= 1'b1;
              r_state    <= S_FIN;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            if (r_addr == ADDR_MAX) begin
              r_addr <= '0;
              r_bank <= r_bank + 2'd1;
              if (r_bank == r_bank_last) r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          // A rejected range spends one extra cycle here before its done/err pulse.
          if (r_err_pend) begin
            r_err_pend <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_dl_valid    <= '0;
      r_dl_bank     <= '0;
      r_dl_last     <= '0;
      r_outstanding <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fifo_count  <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_bank[i]  <= r_dl_bank[i-1];
        r_dl_last[i]  <= r_dl_last[i-1];
      end
      r_dl_valid[0] <= w_issue;
      r_dl_bank[0]  <= r_bank;
      r_dl_last[0]  <= w_issue_last;

      r_outstanding <= r_outstanding + CNT_W'(w_issue) - CNT_W'(w_fifo_wr);
      r_fifo_count  <= r_fifo_count + CNT_W'(w_fifo_wr) - CNT_W'(w_pop);

      if (w_fifo_wr) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_fifo_wr) begin
      r_fifo_data[r_wr_ptr] <= w_rd_q;
      r_fifo_bank[r_wr_ptr] <= r_dl_bank[RD_LATENCY-1];
      r_fifo_last[r_wr_ptr] <= r_dl_last[RD_LATENCY-1];
    end
  end

`ifdef CAPTURE_READOUT_CHECKSUM_EN
  logic [15:0] r_checksum;

  assign o_checksum = r_checksum;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_checksum <= 16'd0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_checksum <= 16'd0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + 16'(o_out_data);
    end
  end
`endif

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Reader counterpart to the sample-capture writer.
- Streams previously captured 16-bit samples back out of the three 65536-word capture banks, in address order, over a valid/ready interface toward the host/UART/analysis path.
- Drives each bank's address and read-enable, absorbs the memory read latency in a small credit-controlled FIFO, and tags each output word with its bank and a last flag.

Parameters:
- ADDR_W, 16, bank address width; bank depth = 2^ADDR_W.
- DATA_W, 16, sample width.
- NUM_BANKS, 3, number of capture banks.
- RD_LATENCY, 2, cycles from mem_rden/mem_address to valid mem_qN.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+1 for full throughput.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- bank_first  in  2  first bank to read; sampled with start.
- bank_last  in  2  last bank to read; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse marking the end of a dump.
- err  out  1  one-cycle pulse, coincident with done, for an invalid range.
- mem_address  out  ADDR_W  read address, shared by all banks.
- mem_rden  out  NUM_BANKS  one-hot per-bank read enable.
- mem_q0, mem_q1, mem_q2  in  DATA_W  bank read data.
- out_data  out  DATA_W  sample.
- out_bank  out  2  bank the sample came from.
- out_last  out  1  marks the final word of the dump.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accepts the word.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - busy, done, err, out_valid, out_last, mem_rden are 0.
  - mem_address, out_data and out_bank are 0.
  - FIFO is emptied and the credit counter cleared.
  - In-flight reads are discarded: a reset mid-dump aborts it with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE:
    - start=1 with a valid range (bank_first <= bank_last < NUM_BANKS): latch both values, set the current bank to bank_first and address to 0, go to ISSUE.
    - start=1 with an invalid range: go to FIN with err set. No reads are issued and no words are emitted.
  - ISSUE:
    - Issue one read per cycle when outstanding + fifo_count < FIFO_DEPTH; issue means mem_rden[bank]=1 with the current address.
    - Otherwise hold mem_rden at 0 (backpressure stall).
    - Address increments after each issue.
    - At address 2^ADDR_W-1: wrap to 0 and advance the bank. If that was bank_last, go to DRAIN after the issue.
  - DRAIN: wait until outstanding = 0 and the FIFO is empty, i.e. the last word has been accepted by the handshake. Then go to FIN.
  - FIN: done=1 for one cycle (err=1 too if the range was invalid), then return to IDLE. busy is 1 in ISSUE, DRAIN and FIN.
- Read data path:
  - A delay line of RD_LATENCY stages carries {valid, bank, last} alongside each issued read.
  - At the end of the delay line the selected mem_qN is written into the FIFO.
- Output:
  - out_valid is 1 when the FIFO is non-empty.
  - out_data, out_bank and out_last come from the FIFO head.
  - The word pops when out_valid & out_ready.
  - With out_valid=1, out_data, out_bank and out_last stay stable until the word is accepted.
  - out_last=1 only on the word with address 2^ADDR_W-1 of bank_last.
- Latency: with start accepted at cycle T and out_ready held at 1:
  - First mem_rden is at T+1.
  - First out_valid is at T+2+RD_LATENCY.
  - One word is emitted per cycle thereafter, with no bubbles, including across bank boundaries.
- Word count: (bank_last − bank_first + 1)·2^ADDR_W.
- Credit invariant: outstanding + fifo_count never exceeds FIFO_DEPTH, so the FIFO never overflows.
- Simultaneous FIFO write and pop in the same cycle leaves the count unchanged.
- start asserted while busy is ignored and has no effect on the current dump.

Optional Feature:
- Macro: CAPTURE_READOUT_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (16 bits): the modulo-2^16 sum of every out_data accepted in the current dump.
  - checksum clears to 0 on reset and on each accepted start.
  - checksum is final and held from the done cycle until the next accepted start.
- When not defined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Bank0 preloaded with data=address, start with bank_first=0, bank_last=0, out_ready=1 → first out_valid at T+4 with data 0x0000. Then 65536 consecutive words 0x0000..0xFFFF, out_bank=0, out_last only on 0xFFFF, done at the cycle after the last handshake.
- Banks 0/1/2 preloaded with 0x1000+a, 0x2000+a, 0x3000+a; range 0..2 → 196608 words with no gap at the bank transitions. out_bank steps 0→1→2; exactly one out_last.
- Range 1..1, out_ready toggling pseudo-randomly (≈50%) → no lost or duplicated words, FIFO never overflows, out_data held stable while stalled.
- bank_first=2, bank_last=1, and separately bank_first=3 → done=err=1 two cycles after start, mem_rden never asserted, out_valid never asserted.
- rst=1 after 1000 words mid-dump → all outputs 0 on the next cycle, no done pulse. A new start then dumps correctly from address 0.
- start pulsed while busy → ignored; with the checksum macro defined, a data=address single-bank dump gives checksum 0x8000 (sum 0..65535 mod 2^16).
